// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: memory access-size codes and
// the grant-record state encoding.
package dmem_arbiter_pkg;

   localparam logic [1:0] OP_WORD = 2'b00;
   localparam logic [1:0] OP_HALF = 2'b01;
   localparam logic [1:0] OP_BYTE = 2'b10;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      GNT_I    = 2'b01,
      GNT_D_RD = 2'b10,
      GNT_D_WR = 2'b11
   } arb_state_e;

endpackage

// File: rtl/dmem_arb_fair_ctr.sv
// Streak counter of consecutive contended data grants; force_i lets the fetch
// requester through once the streak reaches MAX_STREAK.
module dmem_arb_fair_ctr #(
   parameter int MAX_STREAK = 3,
   parameter int STREAK_W   = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic grant_i,
   input  logic grant_d,
   output logic force_i
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

   logic [STREAK_W-1:0] streak_q;
   logic [STREAK_W-1:0] streak_d;

   always_comb begin
      streak_d = streak_q;
      if (grant_i || !i_req) begin
         streak_d = '0;
      end else if (grant_d && (streak_q != STREAK_MAX)) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

   assign force_i = (streak_q == STREAK_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between instruction fetch and MEM-stage load/store.
// Optional misaligned-access trapping is built when DMEM_ARB_ALIGN_CHECK_EN is defined.
//
// state    | meaning
// IDLE     | no access granted last cycle
// GNT_I    | fetch read granted last cycle, fetch response valid now
// GNT_D_RD | data load granted last cycle, load response valid now
// GNT_D_WR | data store granted last cycle, no response
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int MAX_STREAK = 3,
   parameter int STREAK_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_stall,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [1:0]        d_op,
   output logic              d_stall,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
   output logic              err_misalign,
`endif
   output logic              m_read,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   output logic [1:0]        m_op,
   input  logic [31:0]       m_rdata
);

   arb_state_e  state_q, state_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        grant_i, grant_d;
   logic        force_i;
   logic        misalign;

   dmem_arb_fair_ctr #(
      .MAX_STREAK (MAX_STREAK),
      .STREAK_W   (STREAK_W)
   ) u_fair_ctr (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .grant_i (grant_i),
      .grant_d (grant_d),
      .force_i (force_i)
   );

   assign grant_i = i_req & (~d_req | force_i);
   assign grant_d = d_req & ~grant_i;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   logic err_misalign_q, err_misalign_d;

   always_comb begin
      misalign = 1'b0;
      if (grant_d) begin
         case (d_op)
            OP_WORD: misalign = (d_addr[1:0] != 2'b00);
            OP_HALF: misalign = d_addr[0];
            OP_BYTE: misalign = 1'b0;
            default: misalign = 1'b1;
         endcase
      end
      err_misalign_d = misalign;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_misalign_q <= 1'b0;
      end else begin
         err_misalign_q <= err_misalign_d;
      end
   end

   assign err_misalign = err_misalign_q;
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      m_read    = 1'b0;
      m_write   = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      m_op      = OP_WORD;
      state_d   = IDLE;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      if (grant_i) begin
         m_read    = 1'b1;
         m_addr    = i_addr;
         state_d   = GNT_I;
         i_rdata_d = m_rdata;
      end else if (grant_d) begin
         m_read  = ~d_we & ~misalign;
         m_write = d_we & ~misalign;
         m_addr  = d_addr;
         m_wdata = d_wdata;
         m_op    = d_op;
         if (d_we) begin
            state_d = GNT_D_WR;
         end else begin
            state_d   = GNT_D_RD;
            // a trapped load still completes, but with zero data
            d_rdata_d = misalign ? 32'h0 : m_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign i_stall  = i_req & ~grant_i;
   assign d_stall  = d_req & ~grant_d;
   assign i_rvalid = (state_q == GNT_I);
   assign d_rvalid = (state_q == GNT_D_RD);
   assign i_rdata  = i_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-addressable data memory port (6-bit address, mem_op 00 word / 01 half / 10 byte) between the instruction-fetch requester and the MEM-stage load/store requester of the pipelined RISC-V core.
- Grants at most one access per cycle.
- Registers read data back to the owner, with a one-cycle valid pulse.
- Produces per-requester stall signals for the hazard unit.
- Data side has priority; a bounded-streak fairness counter prevents fetch starvation.

Parameters:
ADDR_W, 6, byte address width of both requesters and the memory port
MAX_STREAK, 3, consecutive contended data grants allowed before fetch is forced through
STREAK_W, 2, width of the streak counter; must hold MAX_STREAK

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous, active-high reset
i_req  in  1  fetch request, always a word read
i_addr  in  ADDR_W  fetch byte address
i_stall  out  1  combinational: i_req & ~grant_i
i_rvalid  out  1  one-cycle pulse, the cycle after a fetch grant
i_rdata  out  32  registered fetch data, held until next fetch response
d_req  in  1  MEM-stage request
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data
d_op  in  2  access size, memory encoding
d_stall  out  1  combinational: d_req & ~grant_d
d_rvalid  out  1  one-cycle pulse, the cycle after a granted load; never for stores
d_rdata  out  32  registered load data, held until next load response
m_read  out  1  memory read enable
m_write  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  32  memory write data
m_op  out  2  memory access size
m_rdata  in  32  combinational memory read data

Behaviour:
- **Reset.** Synchronous active-high. Next edge clears:
  - i_rvalid, d_rvalid, i_rdata, d_rdata = 0
  - streak = 0, state = IDLE
  - Memory-port outputs are combinational from the grant; with no grant they are 0.
  - A response pending at reset is dropped, with no valid pulse.
- **Grant logic** (combinational, each cycle):
  - Only d_req: grant_d.
  - Only i_req: grant_i.
  - Both: grant_i if streak == MAX_STREAK, else grant_d.
  - Neither: no grant; m_read = m_write = 0, m_addr/m_wdata/m_op = 0.
- **Memory drive.**
  - grant_i: m_read=1, m_op=00, m_addr=i_addr.
  - grant_d: m_read=~d_we, m_write=d_we, m_addr=d_addr, m_op=d_op, m_wdata=d_wdata.
  - Addresses are passed unmodified; no wrap or range handling in the arbiter.
- **States** (record of last cycle's grant, used for response routing):
  - IDLE, GNT_I, GNT_D_RD, GNT_D_WR.
  - Next state = grant type this cycle.
  - At each edge with grant_i: i_rdata <= m_rdata; i_rvalid = 1 next cycle.
  - At each edge with a load grant_d: d_rdata <= m_rdata; d_rvalid = 1 next cycle.
  - Latency: exactly 1 cycle from grant to valid.
- **Streak counter.**
  - Increments on a cycle with grant_d & i_req.
  - Clears on grant_i or when i_req is low.
  - Never exceeds MAX_STREAK.
  - With MAX_STREAK=3 under continuous contention, fetch gets exactly every 4th cycle.
- **Back-to-back and hold rules.**
  - Back-to-back grants to the same requester are allowed every cycle.
  - A stalled requester must hold its request and operands stable; the arbiter does not buffer them.
  - A store granted while a fetch response pulses is legal; the response registers are independent.

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHECK_EN.
- **Defined:**
  - Port err_misalign (out, 1) is added; reset value 0.
  - A granted data access is misaligned if:
    - d_op == 00 and d_addr[1:0] != 0, or
    - d_op == 01 and d_addr[0] != 0, or
    - d_op == 11.
  - A misaligned access still consumes the grant (d_stall low), but m_read = m_write = 0.
  - Next cycle, err_misalign pulses for 1 cycle.
  - For a misaligned load, d_rvalid also pulses with d_rdata = 0.
  - Fetch is never checked.
- **Undefined:** no port; all accesses are forwarded unchanged.

Decomposition:
- Shared package holds:
  - the mem_op constants (OP_WORD=2'b00, OP_HALF=2'b01, OP_BYTE=2'b10)
  - the state encoding typedef for IDLE/GNT_I/GNT_D_RD/GNT_D_WR
- One natural sub-module: dmem_arb_fair_ctr. It holds the streak counter and outputs force_i = (streak == MAX_STREAK).

Test Plan:
1. Reset mid-response: grant fetch at addr 0, assert rst on the following edge → i_rvalid stays 0, all outputs 0 after the reset edge.
2. Lone fetch: i_req, i_addr=0, m_rdata=32'h11091900 → m_read=1, m_op=00 the same cycle; next cycle i_rvalid=1, i_rdata=32'h11091900; i_stall=0.
3. Store then load: d_we=1, d_addr=8, d_op=10, d_wdata=32'hAB → m_write=1, no d_rvalid; then a load at addr 8 with m_rdata=32'hFFFFFFAB → d_rvalid next cycle, d_rdata=32'hFFFFFFAB.
4. Continuous contention, 8 cycles, MAX_STREAK=3 → grant pattern D,D,D,I,D,D,D,I; i_stall high exactly on the D cycles; streak 0,1,2,3,0,….
5. Simultaneous single requests: only d_req for 2 cycles, then only i_req → immediate grants, no stalls, streak stays 0.
6. With DMEM_ARB_ALIGN_CHECK_EN, load d_op=00 d_addr=2 → m_read=0, d_stall=0; next cycle err_misalign=1, d_rvalid=1, d_rdata=0. Without the macro → m_read=1, m_addr=2.
